// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for rom_arbiter
package rom_arb_pkg;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  localparam logic [31:0] NOP_INSN       = 32'h0000_0013;
  localparam int          ROM_AW_DEFAULT = 9;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } issue_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_IF) ? PORT_LS : PORT_IF;
  endfunction

endpackage

// File: rtl/rom_arb_rsp_slot.sv
// rtl/rom_arb_rsp_slot.sv - per-requester response hold slot and response mux
module rom_arb_rsp_slot
  import rom_arb_pkg::*;
(
  input  logic        clka,
  input  logic        rsta,
  input  logic        issue_hit,
  input  logic        issue_err,
  input  logic [31:0] rom_douta,
  input  logic        rready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        full
);

  logic        full_q;
  logic [31:0] hold_data;
  logic        hold_err;
  logic [31:0] fresh_data;

  // Error responses never expose ROM data.
  assign fresh_data = issue_err ? NOP_INSN : rom_douta;
  assign full       = full_q;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      full_q    <= 1'b0;
      hold_data <= NOP_INSN;
      hold_err  <= 1'b0;
    end else if (full_q) begin
      if (rready) full_q <= 1'b0;
    end else if (issue_hit && !rready) begin
      full_q    <= 1'b1;
      hold_data <= fresh_data;
      hold_err  <= issue_err;
    end
  end

  always_comb begin
    rvalid = 1'b0;
    rdata  = NOP_INSN;
    err    = 1'b0;
    if (full_q) begin
      rvalid = 1'b1;
      rdata  = hold_data;
      err    = hold_err;
    end else if (issue_hit) begin
      rvalid = 1'b1;
      rdata  = fresh_data;
      err    = issue_err;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - IF/LS arbiter for the shared instruction ROM
// ROM_ARBITER_RR_EN selects round-robin ties; otherwise LS wins ties.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int          ROM_AW   = ROM_AW_DEFAULT,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              if_rready,
  input  logic              ls_req,
  input  logic [31:0]       ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  input  logic              ls_rready,
  output logic [ROM_AW-1:0] rom_addra,
  input  logic [31:0]       rom_douta
);

  issue_t      issue_q;
  logic        if_hit, ls_hit, if_full, ls_full;
  logic        if_elig, ls_elig, if_bad, ls_bad;
  logic [31:2] if_off, ls_off;
  port_e       tie_port;

  // The window base is word aligned, so offsets are computed on word bits only.
  assign if_off = if_addr[31:2] - ROM_BASE[31:2];
  assign ls_off = ls_addr[31:2] - ROM_BASE[31:2];
  assign if_bad = (|if_addr[1:0]) || (|if_off[31:ROM_AW+2]);
  assign ls_bad = (|ls_addr[1:0]) || (|ls_off[31:ROM_AW+2]);

  assign if_hit = issue_q.valid && (issue_q.port == PORT_IF);
  assign ls_hit = issue_q.valid && (issue_q.port == PORT_LS);

  assign if_elig = if_req && !if_full && !(if_hit && !if_rready);
  assign ls_elig = ls_req && !ls_full && !(ls_hit && !ls_rready);

`ifdef ROM_ARBITER_RR_EN
  port_e last_q;

  assign tie_port = other_port(last_q);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta)                 last_q <= PORT_LS;
    else if (if_gnt || ls_gnt) last_q <= ls_gnt ? PORT_LS : PORT_IF;
  end
`else
  assign tie_port = PORT_LS;
`endif

  assign if_gnt = !rsta && if_elig && (!ls_elig || tie_port == PORT_IF);
  assign ls_gnt = !rsta && ls_elig && (!if_elig || tie_port == PORT_LS);

  assign rom_addra = if_gnt ? if_off[ROM_AW+1:2] :
                     ls_gnt ? ls_off[ROM_AW+1:2] : '0;

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      issue_q <= '0;
    end else begin
      issue_q.valid <= if_gnt || ls_gnt;
      issue_q.port  <= ls_gnt ? PORT_LS : PORT_IF;
      issue_q.err   <= ls_gnt ? ls_bad : if_bad;
    end
  end

  rom_arb_rsp_slot u_if_slot (
    .clka      (clka),
    .rsta      (rsta),
    .issue_hit (if_hit),
    .issue_err (issue_q.err),
    .rom_douta (rom_douta),
    .rready    (if_rready),
    .rvalid    (if_rvalid),
    .rdata     (if_rdata),
    .err       (if_err),
    .full      (if_full)
  );

  rom_arb_rsp_slot u_ls_slot (
    .clka      (clka),
    .rsta      (rsta),
    .issue_hit (ls_hit),
    .issue_err (issue_q.err),
    .rom_douta (rom_douta),
    .rready    (ls_rready),
    .rvalid    (ls_rvalid),
    .rdata     (ls_rdata),
    .err       (ls_err),
    .full      (ls_full)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - randomized self-checking bench for rom_arbiter
module tb_rom_arbiter;

  localparam int          AW    = 9;
  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clka = 1'b0;
  logic          rsta;
  logic          if_req, ls_req, if_rready, ls_rready;
  logic [31:0]   if_addr, ls_addr;
  logic          if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err;
  logic [31:0]   if_rdata, ls_rdata, rom_douta;
  logic [AW-1:0] rom_addra;
  logic [31:0]   rom_mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the response each requester currently sees.
  bit          m_pend [2];
  int unsigned m_age  [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];
  int          m_last;

  always #5 clka = ~clka;

  rom_arbiter #(.ROM_AW(AW), .ROM_BASE(BASE)) dut (
    .clka(clka), .rsta(rsta),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err), .if_rready(if_rready),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err), .ls_rready(ls_rready),
    .rom_addra(rom_addra), .rom_douta(rom_douta)
  );

  always @(posedge clka or posedge rsta) begin
    if (rsta) rom_douta <= NOP;
    else      rom_douta <= rom_mem[rom_addra];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) % DEPTH);
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_pend[p] = 1'b0;
      m_age[p]  = 0;
      m_data[p] = NOP;
      m_err[p]  = 1'b0;
    end
    m_last = 1;
  endfunction

  task automatic check_resp(input int p);
    logic        v, e;
    logic [31:0] d;
    v = (p == 0) ? if_rvalid : ls_rvalid;
    d = (p == 0) ? if_rdata  : ls_rdata;
    e = (p == 0) ? if_err    : ls_err;
    check_val((p == 0) ? "if_rvalid" : "ls_rvalid", 32'(v), 32'(m_pend[p]));
    check_val((p == 0) ? "if_rdata"  : "ls_rdata",  d, m_pend[p] ? m_data[p] : NOP);
    check_val((p == 0) ? "if_err"    : "ls_err",    32'(e), 32'(m_pend[p] && m_err[p]));
  endtask

  // One clock cycle: drive, compare against the model at negedge, then advance the model.
  task automatic step(input bit ir, input logic [31:0] ia, input bit irr,
                      input bit lr, input logic [31:0] la, input bit lrr, output int win);
    bit          req [2];
    bit          rdy [2];
    bit          el  [2];
    logic [31:0] adr [2];
    logic [31:0] exp_a;
    if_req = ir; if_addr = ia; if_rready = irr;
    ls_req = lr; ls_addr = la; ls_rready = lrr;
    req[0] = ir; req[1] = lr; rdy[0] = irr; rdy[1] = lrr; adr[0] = ia; adr[1] = la;
    @(negedge clka);
    for (int p = 0; p < 2; p++)
      el[p] = req[p] && (!m_pend[p] || (m_age[p] == 0 && rdy[p]));
    win = -1;
    if (el[0] && el[1]) begin
`ifdef ROM_ARBITER_RR_EN
      win = (m_last == 0) ? 1 : 0;
`else
      win = 1;
`endif
    end else if (el[0]) win = 0;
    else if (el[1]) win = 1;
    exp_a = (win < 0) ? 32'd0 : 32'(word_idx(adr[win]));
    check_val("if_gnt", 32'(if_gnt), 32'(win == 0));
    check_val("ls_gnt", 32'(ls_gnt), 32'(win == 1));
    check_val("rom_addra", 32'(rom_addra), exp_a);
    check_resp(0);
    check_resp(1);
    @(posedge clka);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (m_pend[p]) begin
        if (rdy[p]) m_pend[p] = 1'b0;
        else        m_age[p]++;
      end
      if (win == p) begin
        m_pend[p] = 1'b1;
        m_age[p]  = 0;
        m_err[p]  = bad_addr(adr[p]);
        m_data[p] = m_err[p] ? NOP : rom_mem[word_idx(adr[p])];
        m_last    = p;
      end
    end
  endtask

  task automatic check_in_reset();
    check_val("rst_if_gnt",    32'(if_gnt),    32'd0);
    check_val("rst_ls_gnt",    32'(ls_gnt),    32'd0);
    check_val("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_val("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check_val("rst_if_rdata",  if_rdata,       NOP);
    check_val("rst_ls_rdata",  ls_rdata,       NOP);
    check_val("rst_ls_err",    32'(ls_err),    32'd0);
    check_val("rst_rom_addra", 32'(rom_addra), 32'd0);
  endtask

  // Reset asserted between clock edges with both requesters asking.
  task automatic mid_reset();
    if_req = 1'b1; if_addr = 32'h8; ls_req = 1'b1; ls_addr = 32'hC;
    #2;
    rsta = 1'b1;
    #1;
    check_in_reset();
    @(posedge clka);
    #1;
    check_in_reset();
    rsta = 1'b0;
    model_reset();
  endtask

  initial begin
    int w;
    bit          cr [2];
    logic [31:0] ca [2];
    bit          irr, lrr;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = $urandom;
    rsta = 1'b1;
    if_req = 1'b1; if_addr = 32'h10; if_rready = 1'b1;
    ls_req = 1'b0; ls_addr = 32'h0;  ls_rready = 1'b1;
    model_reset();

    @(posedge clka);
    #1;
    check_in_reset();
    @(posedge clka);
    #1;
    check_in_reset();
    rsta = 1'b0;

    step(1, 32'h10, 1, 0, 0, 1, w);
    step(0, 32'h0,  1, 0, 0, 1, w);
    for (int i = 0; i < 3; i++) step(1, 32'(4 * i), 1, 0, 0, 1, w);
    step(0, 0, 1, 0, 0, 1, w);

    for (int i = 0; i < 6; i++) step(1, 32'(4 * i), 1, 1, 32'(32'h100 + 4 * i), 1, w);
    step(0, 0, 1, 0, 0, 1, w);

    step(0, 0, 1, 1, 32'h20, 0, w);
    for (int i = 0; i < 3; i++) step(1, 32'(32'h40 + 4 * i), 1, 1, 32'h24, 0, w);
    step(1, 32'h50, 1, 1, 32'h24, 1, w);
    step(1, 32'h54, 1, 1, 32'h24, 1, w);
    step(0, 0, 1, 1, 32'h24, 1, w);
    step(0, 0, 1, 0, 0, 1, w);

    step(0, 0, 1, 1, 32'h802, 1, w);
    step(0, 0, 1, 0, 0, 1, w);

    step(0, 0, 1, 1, 32'h30, 0, w);
    step(0, 0, 1, 0, 0, 0, w);
    mid_reset();
    step(0, 0, 1, 0, 0, 1, w);
    step(0, 0, 1, 0, 0, 1, w);

    for (int p = 0; p < 2; p++) begin cr[p] = 1'b0; ca[p] = 32'h0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!cr[p] && $urandom_range(0, 2) == 0) begin
          cr[p] = 1'b1;
          if ($urandom_range(0, 7) == 0) ca[p] = $urandom;
          else ca[p] = {21'b0, 9'($urandom_range(0, DEPTH - 1)), 2'b00};
        end
      end
      irr = ($urandom_range(0, 3) != 0);
      lrr = ($urandom_range(0, 3) != 0);
      step(cr[0], ca[0], irr, cr[1], ca[1], lrr, w);
      if (w >= 0) cr[w] = 1'b0;
      if (cyc % 500 == 250) begin
        mid_reset();
        cr[0] = 1'b0;
        cr[1] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
